ghost_mover: RTL and testbench



---
 rtl/ghost_mover.sv | 227 ++++++++++++++++++++++
 tb/tb_ghost_mover.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mover.sv
// ghost_mover: moves a ghost sprite one STEP per accepted frame.
// Each frame first tries the pending direction, falls back to the current
// direction if that is blocked, and stays put if both are blocked.
// Ports:
//   Clk, Reset (async, active-low)      clock / reset
//   frame_tick                          one pulse per frame
//   dir_valid, dir_in[7:0]              direction code strobe
//   probe_valid, probe_x, probe_y       wall query for a candidate position
//   wall_valid, wall_hit                wall query response
//   ghost_x, ghost_y                    current position
//   cur_dir[1:0]                        applied direction (0 L, 1 R, 2 D, 3 U)
//   moved                               one-cycle pulse on position change
//   overrun                             sticky: frame_tick arrived while busy
module ghost_mover #(
  parameter logic [9:0] START_X       = 10'd320,
  parameter logic [9:0] START_Y       = 10'd240,
  parameter logic [9:0] STEP          = 10'd1,
  parameter logic [9:0] X_MIN         = 10'd16,
  parameter logic [9:0] X_MAX         = 10'd623,
  parameter logic [9:0] Y_MIN         = 10'd16,
  parameter logic [9:0] Y_MAX         = 10'd463,
  parameter logic [3:0] PROBE_TIMEOUT = 4'd15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       dir_valid,
  input  logic [7:0] dir_in,
  output logic       probe_valid,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  input  logic       wall_valid,
  input  logic       wall_hit,
  output logic [9:0] ghost_x,
  output logic [9:0] ghost_y,
  output logic [1:0] cur_dir,
  output logic       moved,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PROBE_PEND = 3'd1,
    WAIT_PEND  = 3'd2,
    PROBE_CUR  = 3'd3,
    WAIT_CUR   = 3'd4,
    APPLY      = 3'd5
  } state_t;

  function automatic logic code_ok(input logic [7:0] c);
    case (c)
      8'h04, 8'h07, 8'h16, 8'h1A: code_ok = 1'b1;
      default:                    code_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] code_dir(input logic [7:0] c);
    case (c)
      8'h04:   code_dir = 2'd0;
      8'h07:   code_dir = 2'd1;
      8'h16:   code_dir = 2'd2;
      8'h1A:   code_dir = 2'd3;
      default: code_dir = 2'd0;
    endcase
  endfunction

  // Candidate position {x, y}; plain 10-bit arithmetic so an underflow wraps
  // high and an overflow wraps low, both of which fail the bounds check.
  function automatic logic [19:0] step_pos(input logic [9:0] x, input logic [9:0] y,
                                           input logic [1:0] dir);
    case (dir)
      2'd0:    step_pos = {x - STEP, y};
      2'd1:    step_pos = {x + STEP, y};
      2'd2:    step_pos = {x, y + STEP};
      2'd3:    step_pos = {x, y - STEP};
      default: step_pos = {x, y};
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [9:0] probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic [1:0] cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d, frame_dir_q, frame_dir_d;
  logic [3:0] tmo_q, tmo_d;
  logic       probe_valid_q, probe_valid_d, moved_q, moved_d, overrun_q, overrun_d;

  logic [1:0] probe_dir_s;
  logic [9:0] pc_x_s, pc_y_s;
  logic       pc_in_s, wait_done_s, wait_blocked_s, same_dir_s, code_ok_s;

  // Shared decode of the current probe candidate and wait resolution.
  always_comb begin
    probe_dir_s      = (state_q == PROBE_PEND) ? frame_dir_q : cur_dir_q;
    {pc_x_s, pc_y_s} = step_pos(x_q, y_q, probe_dir_s);
    pc_in_s          = (pc_x_s >= X_MIN) && (pc_x_s <= X_MAX) &&
                       (pc_y_s >= Y_MIN) && (pc_y_s <= Y_MAX);
    wait_done_s      = wall_valid || (tmo_q == (PROBE_TIMEOUT - 4'd1));
    wait_blocked_s   = wall_valid ? wall_hit : 1'b1;
    same_dir_s       = (frame_dir_q == cur_dir_q);
    code_ok_s        = dir_valid && code_ok(dir_in);
  end

  // State and data registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      x_q           <= START_X;
      y_q           <= START_Y;
      cand_x_q      <= START_X;
      cand_y_q      <= START_Y;
      probe_x_q     <= 10'd0;
      probe_y_q     <= 10'd0;
      cur_dir_q     <= 2'd0;
      pend_dir_q    <= 2'd0;
      frame_dir_q   <= 2'd0;
      tmo_q         <= 4'd0;
      probe_valid_q <= 1'b0;
      moved_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      probe_x_q     <= probe_x_d;
      probe_y_q     <= probe_y_d;
      cur_dir_q     <= cur_dir_d;
      pend_dir_q    <= pend_dir_d;
      frame_dir_q   <= frame_dir_d;
      tmo_q         <= tmo_d;
      probe_valid_q <= probe_valid_d;
      moved_q       <= moved_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state logic and wait-timeout counter.
  always_comb begin
    state_d = state_q;
    tmo_d   = 4'd0;
    case (state_q)
      IDLE:       state_d = frame_tick ? PROBE_PEND : IDLE;
      // Out-of-bounds candidate is resolved here as blocked, with no probe.
      PROBE_PEND: begin
        if (pc_in_s)         state_d = WAIT_PEND;
        else if (same_dir_s) state_d = IDLE;
        else                 state_d = PROBE_CUR;
      end
      WAIT_PEND: begin
        if (!wait_done_s)        tmo_d = tmo_q + 4'd1;
        else                     tmo_d = 4'd0;
        if (!wait_done_s)        state_d = WAIT_PEND;
        else if (!wait_blocked_s) state_d = APPLY;
        else if (same_dir_s)     state_d = IDLE;
        else                     state_d = PROBE_CUR;
      end
      PROBE_CUR:  state_d = pc_in_s ? WAIT_CUR : IDLE;
      WAIT_CUR: begin
        if (!wait_done_s)        tmo_d = tmo_q + 4'd1;
        else                     tmo_d = 4'd0;
        if (!wait_done_s)        state_d = WAIT_CUR;
        else if (!wait_blocked_s) state_d = APPLY;
        else                     state_d = IDLE;
      end
      APPLY:      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    probe_x_d     = probe_x_q;
    probe_y_d     = probe_y_q;
    cur_dir_d     = cur_dir_q;
    frame_dir_d   = frame_dir_q;
    probe_valid_d = 1'b0;
    moved_d       = 1'b0;
    pend_dir_d    = code_ok_s ? code_dir(dir_in) : pend_dir_q;
    overrun_d     = overrun_q | (frame_tick && (state_q != IDLE));
    case (state_q)
      // A strobe in the same cycle as the frame tick takes priority.
      IDLE: begin
        if (frame_tick) frame_dir_d = code_ok_s ? code_dir(dir_in) : pend_dir_q;
        else            frame_dir_d = frame_dir_q;
      end
      PROBE_PEND, PROBE_CUR: begin
        cand_x_d = pc_x_s;
        cand_y_d = pc_y_s;
        if (pc_in_s) begin
          probe_valid_d = 1'b1;
          probe_x_d     = pc_x_s;
          probe_y_d     = pc_y_s;
        end else begin
          probe_valid_d = 1'b0;
        end
      end
      WAIT_PEND: begin
        if (wait_done_s && !wait_blocked_s) cur_dir_d = frame_dir_q;
        else                                cur_dir_d = cur_dir_q;
      end
      APPLY: begin
        x_d     = cand_x_q;
        y_d     = cand_y_q;
        moved_d = 1'b1;
      end
      default: begin
        moved_d = 1'b0;
      end
    endcase
  end

  assign probe_valid = probe_valid_q;
  assign probe_x     = probe_x_q;
  assign probe_y     = probe_y_q;
  assign ghost_x     = x_q;
  assign ghost_y     = y_q;
  assign cur_dir     = cur_dir_q;
  assign moved       = moved_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ghost_mover.sv
module tb_ghost_mover;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       dir_valid = 1'b0;
  logic [7:0] dir_in = 8'h00;
  logic       wall_valid = 1'b0;
  logic       wall_hit = 1'b0;
  logic       probe_valid, moved, overrun;
  logic [9:0] probe_x, probe_y, ghost_x, ghost_y;
  logic [1:0] cur_dir;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  logic [19:0] exp_probe_q[$];
  logic [19:0] exp_move_q[$];
  logic        hit_q[$];
  int          probe_cyc_q[$];

  bit resp_en  = 1'b1;
  int resp_dly = 0;
  int resp_cnt = -1;

  ghost_mover dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .dir_valid(dir_valid),
    .dir_in(dir_in), .probe_valid(probe_valid), .probe_x(probe_x), .probe_y(probe_y),
    .wall_valid(wall_valid), .wall_hit(wall_hit), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .cur_dir(cur_dir), .moved(moved), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Wall responder: answers a seen probe resp_dly cycles later with the next queued hit.
  always begin
    @(negedge Clk);
    if (Reset && probe_valid && resp_en) resp_cnt = resp_dly;
    @(posedge Clk);
    #1;
    wall_valid = 1'b0;
    wall_hit   = 1'b0;
    if (resp_cnt == 0) begin
      wall_valid = 1'b1;
      wall_hit   = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
      resp_cnt   = -1;
    end else if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
    end
  end

  // Scoreboard monitor: every probe and every move must match the next expected entry.
  always @(negedge Clk) begin
    logic [19:0] e;
    cyc = cyc + 1;
    if (Reset) begin
      if (probe_valid) begin
        probe_cyc_q.push_back(cyc);
        chk_cnt = chk_cnt + 1;
        if (exp_probe_q.size() == 0) begin
          $display("FAIL probe_unexpected got (%0d,%0d) exp no probe", probe_x, probe_y);
        end else begin
          e = exp_probe_q.pop_front();
          if ({probe_x, probe_y} !== e)
            $display("FAIL probe_pos got (%0d,%0d) exp (%0d,%0d)", probe_x, probe_y, e[19:10], e[9:0]);
          else pass_cnt = pass_cnt + 1;
        end
      end
      if (moved) begin
        chk_cnt = chk_cnt + 1;
        if (exp_move_q.size() == 0) begin
          $display("FAIL move_unexpected got (%0d,%0d) exp no move", ghost_x, ghost_y);
        end else begin
          e = exp_move_q.pop_front();
          if ({ghost_x, ghost_y} !== e)
            $display("FAIL move_pos got (%0d,%0d) exp (%0d,%0d)", ghost_x, ghost_y, e[19:10], e[9:0]);
          else pass_cnt = pass_cnt + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic load_dir(input logic [7:0] code);
    dir_valid = 1'b1;
    dir_in    = code;
    tick(1);
    dir_valid = 1'b0;
    dir_in    = 8'h00;
  endtask

  task automatic pulse_frame;
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
  endtask

  task automatic check_pos(input string name, input logic [9:0] ex, input logic [9:0] ey);
    chk_cnt = chk_cnt + 1;
    if ({ghost_x, ghost_y} !== {ex, ey})
      $display("FAIL %s got (%0d,%0d) exp (%0d,%0d)", name, ghost_x, ghost_y, ex, ey);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic check_dir(input string name, input logic [1:0] ed);
    chk_cnt = chk_cnt + 1;
    if (cur_dir !== ed) $display("FAIL %s got %0d exp %0d", name, cur_dir, ed);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic check_overrun(input string name, input logic eo);
    chk_cnt = chk_cnt + 1;
    if (overrun !== eo) $display("FAIL %s got %0b exp %0b", name, overrun, eo);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_reset;
    #1;
    check_pos("reset_pos", 10'd320, 10'd240);
    check_dir("reset_dir", 2'd0);
    check_overrun("reset_overrun", 1'b0);
    chk_cnt = chk_cnt + 1;
    if ({probe_valid, moved} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {probe_valid, moved});
    else pass_cnt = pass_cnt + 1;
    tick(1);
    Reset = 1'b1;
    tick(2);
  endtask

  task automatic test_move_right;
    load_dir(8'h07);
    exp_probe_q.push_back({10'd321, 10'd240});
    exp_move_q.push_back({10'd321, 10'd240});
    hit_q.push_back(1'b0);
    pulse_frame();
    tick(10);
    check_pos("right_pos", 10'd321, 10'd240);
    check_dir("right_dir", 2'd1);
  endtask

  task automatic test_fallback;
    load_dir(8'h1A);
    exp_probe_q.push_back({10'd321, 10'd239});
    exp_probe_q.push_back({10'd322, 10'd240});
    exp_move_q.push_back({10'd322, 10'd240});
    hit_q.push_back(1'b1);
    hit_q.push_back(1'b0);
    pulse_frame();
    tick(14);
    check_pos("fallback_pos", 10'd322, 10'd240);
    check_dir("fallback_dir", 2'd1);
  endtask

  // Strobe in the same cycle as the frame; pending equals current and is blocked.
  task automatic test_same_dir_blocked;
    exp_probe_q.push_back({10'd323, 10'd240});
    hit_q.push_back(1'b1);
    dir_valid  = 1'b1;
    dir_in     = 8'h07;
    frame_tick = 1'b1;
    tick(1);
    dir_valid  = 1'b0;
    frame_tick = 1'b0;
    tick(12);
    check_pos("same_dir_pos", 10'd322, 10'd240);
  endtask

  task automatic test_left_bound;
    logic [9:0] ex;
    ex = 10'd322;
    load_dir(8'h04);
    for (int i = 0; i < 306; i++) begin
      ex = ex - 10'd1;
      exp_probe_q.push_back({ex, 10'd240});
      exp_move_q.push_back({ex, 10'd240});
      hit_q.push_back(1'b0);
      pulse_frame();
      tick(7);
    end
    check_pos("walk_left_pos", 10'd16, 10'd240);
    check_dir("walk_left_dir", 2'd0);
    pulse_frame();
    tick(10);
    check_pos("xmin_blocked_pos", 10'd16, 10'd240);
    load_dir(8'h16);
    exp_probe_q.push_back({10'd16, 10'd241});
    exp_move_q.push_back({10'd16, 10'd241});
    hit_q.push_back(1'b0);
    pulse_frame();
    tick(10);
    check_dir("down_dir", 2'd2);
    load_dir(8'h04);
    exp_probe_q.push_back({10'd16, 10'd242});
    exp_move_q.push_back({10'd16, 10'd242});
    hit_q.push_back(1'b0);
    pulse_frame();
    tick(12);
    check_pos("xmin_fallback_pos", 10'd16, 10'd242);
    check_dir("xmin_fallback_dir", 2'd2);
  endtask

  task automatic test_timeout;
    load_dir(8'h1A);
    load_dir(8'h55);
    resp_en = 1'b0;
    probe_cyc_q.delete();
    exp_probe_q.push_back({10'd16, 10'd241});
    exp_probe_q.push_back({10'd16, 10'd243});
    pulse_frame();
    tick(45);
    chk_cnt = chk_cnt + 1;
    if (probe_cyc_q.size() != 2) begin
      $display("FAIL timeout_probes got %0d exp 2", probe_cyc_q.size());
    end else if (probe_cyc_q[1] - probe_cyc_q[0] != 16) begin
      $display("FAIL timeout_gap got %0d exp 16", probe_cyc_q[1] - probe_cyc_q[0]);
    end else pass_cnt = pass_cnt + 1;
    check_pos("timeout_pos", 10'd16, 10'd242);
    check_dir("timeout_dir", 2'd2);
    check_overrun("timeout_overrun", 1'b0);
    resp_en = 1'b1;
  endtask

  task automatic test_overrun;
    resp_dly = 3;
    exp_probe_q.push_back({10'd16, 10'd241});
    exp_move_q.push_back({10'd16, 10'd241});
    hit_q.push_back(1'b0);
    pulse_frame();
    tick(1);
    pulse_frame();
    tick(30);
    check_overrun("overrun_set", 1'b1);
    check_pos("overrun_pos", 10'd16, 10'd241);
    check_dir("overrun_dir", 2'd3);
  endtask

  task automatic test_reset_mid_wait;
    resp_dly = 5;
    exp_probe_q.push_back({10'd16, 10'd240});
    hit_q.push_back(1'b0);
    pulse_frame();
    tick(3);
    Reset = 1'b0;
    #1;
    check_pos("midreset_pos", 10'd320, 10'd240);
    check_overrun("midreset_overrun", 1'b0);
    check_dir("midreset_dir", 2'd0);
    tick(2);
    Reset = 1'b1;
    tick(20);
    check_pos("late_resp_pos", 10'd320, 10'd240);
    resp_dly = 0;
  endtask

  initial begin
    tick(2);
    test_reset();
    test_move_right();
    test_fallback();
    test_same_dir_blocked();
    test_left_bound();
    test_timeout();
    test_overrun();
    test_reset_mid_wait();
    chk_cnt = chk_cnt + 1;
    if (exp_probe_q.size() != 0 || exp_move_q.size() != 0)
      $display("FAIL scoreboard_drain got %0d probes %0d moves exp 0 0", exp_probe_q.size(), exp_move_q.size());
    else pass_cnt = pass_cnt + 1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
